mem_port_arbiter: RTL and testbench

- Sequences and shares the single-ported unified memory between two requesters: the multicycle core (fetch, load and store accesses, selected by IorD) and an external loader/debug port (ext).
- The core's control FSM holds in its memory state until cpu_done.
- The ext port can halt the core at a transaction boundary to load programs or inspect memory.
- One transaction is in flight at a time; memory read latency is fixed and parameterised.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the core and an external loader port.
// One transaction in flight at a time. The fixed read latency counts from the grant edge.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_halted,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_done,
  output logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_halt,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic {OWN_CPU, OWN_EXT} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d, last_owner_q, last_owner_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic                cpu_done_q, cpu_done_d, ext_done_q, ext_done_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d, ext_rdata_q, ext_rdata_d;
  logic                cpu_halted_q, cpu_halted_d;
  logic                cpu_elig, ext_elig, grant_cpu, grant_ext;

  // Round-robin only matters on a tie; a halted core is simply ineligible.
  assign cpu_elig  = cpu_req && !ext_halt;
  assign ext_elig  = ext_req;
  assign grant_cpu = (state_q == S_IDLE) && cpu_elig && (!ext_elig || last_owner_q == OWN_EXT);
  assign grant_ext = (state_q == S_IDLE) && ext_elig && (!cpu_elig || last_owner_q == OWN_CPU);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    lat_cnt_d    = lat_cnt_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    cpu_done_d   = 1'b0;
    ext_done_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    cpu_halted_d = ext_halt && !(state_q != S_IDLE && owner_q == OWN_CPU);
    case (state_q)
      S_IDLE: begin
        if (grant_cpu || grant_ext) begin
          owner_d      = grant_cpu ? OWN_CPU : OWN_EXT;
          last_owner_d = owner_d;
          we_d         = grant_cpu ? cpu_we    : ext_we;
          mem_addr_d   = grant_cpu ? cpu_addr  : ext_addr;
          mem_wdata_d  = grant_cpu ? cpu_wdata : ext_wdata;
          mem_read_d   = !we_d;
          mem_write_d  = we_d;
          lat_cnt_d    = 4'(MEM_LATENCY);
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        state_d   = S_WAIT;
        // lat_cnt==1 marks the cycle mem_rdata is valid; with latency 1 that is the strobe cycle.
        if (lat_cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (owner_q == OWN_CPU) begin
            cpu_done_d = 1'b1;
            if (!we_q) cpu_rdata_d = mem_rdata;
          end else begin
            ext_done_d = 1'b1;
            if (!we_q) ext_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_EXT;
      last_owner_q <= OWN_EXT;
      lat_cnt_q    <= 4'd0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      cpu_done_q   <= 1'b0;
      ext_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      cpu_halted_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      lat_cnt_q    <= lat_cnt_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      cpu_done_q   <= cpu_done_d;
      ext_done_q   <= ext_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
      cpu_halted_q <= cpu_halted_d;
    end
  end

  assign cpu_gnt    = grant_cpu && !resetn;
  assign ext_gnt    = grant_ext && !resetn;
  assign cpu_done   = cpu_done_q;
  assign ext_done   = ext_done_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ext_rdata  = ext_rdata_q;
  assign cpu_halted = cpu_halted_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random two-requester traffic with halt toggling and mid-transaction resets,
// checked every cycle against a transaction-level timing model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, LAT = 3, NCYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, cpu_req, cpu_we, cpu_gnt, cpu_done, cpu_halted;
  logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, ext_wdata, ext_rdata, mem_wdata, mem_rdata;
  logic          ext_req, ext_we, ext_gnt, ext_done, ext_halt, mem_read, mem_write;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_halted(cpu_halted),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_rdata(ext_rdata), .ext_halt(ext_halt),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i * 257);
  endfunction

  // Environment memory: data is valid combinationally from the latched address.
  logic [DW-1:0] tb_mem [16];
  logic          init_mem;
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 16; i++) tb_mem[i] <= init_word(i);
    else if (mem_write) tb_mem[mem_addr[3:0]] <= mem_wdata;
  end
  assign mem_rdata = tb_mem[mem_addr[3:0]];

  int n_tests = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a transaction granted in cycle g strobes at g+1, occupies
  // the port through g+LAT and reports done at g+LAT+1.
  logic [DW-1:0] ref_mem [16];
  int            busy_until, issue_at, done_at;
  logic          own_cpu, cur_we, last_cpu, exp_halted, post_rst, g_cpu, g_ext, rst_arm;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata, cur_rval, exp_cpu_rd, exp_ext_rd;

  task automatic model_step();
    logic free, inflight, cel, eel, ec, ee, dn;
    dn = (cyc == done_at);
    if (dn && !cur_we) begin
      if (own_cpu) exp_cpu_rd = cur_rval;
      else         exp_ext_rd = cur_rval;
    end
    chk("cpu_done",  cpu_done,  dn && own_cpu);
    chk("ext_done",  ext_done,  dn && !own_cpu);
    chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
    chk("ext_rdata", ext_rdata, exp_ext_rd);
    chk("mem_read",  mem_read,  cyc == issue_at && !cur_we);
    chk("mem_write", mem_write, cyc == issue_at && cur_we);
    if (cyc >= issue_at && cyc <= busy_until) begin
      chk("mem_addr",  mem_addr,  cur_addr);
      chk("mem_wdata", mem_wdata, cur_wdata);
    end
    if (post_rst) begin
      chk("rst_addr",  mem_addr,  0);
      chk("rst_wdata", mem_wdata, 0);
      post_rst = 1'b0;
    end
    chk("cpu_halted", cpu_halted, exp_halted);

    free     = cyc > busy_until;
    inflight = !free && own_cpu;
    cel      = cpu_req && !ext_halt;
    eel      = ext_req;
    ec       = free && !resetn && cel && (!eel || !last_cpu);
    ee       = free && !resetn && eel && (!cel || last_cpu);
    chk("cpu_gnt", cpu_gnt, ec);
    chk("ext_gnt", ext_gnt, ee);

    exp_halted = resetn ? 1'b0 : (ext_halt && !inflight);
    if (resetn) begin
      busy_until = -1; issue_at = -1; done_at = -1; last_cpu = 1'b0;
      exp_cpu_rd = '0; exp_ext_rd = '0; post_rst = 1'b1;
    end else if (ec || ee) begin
      own_cpu    = ec;
      last_cpu   = ec;
      cur_we     = ec ? cpu_we    : ext_we;
      cur_addr   = ec ? cpu_addr  : ext_addr;
      cur_wdata  = ec ? cpu_wdata : ext_wdata;
      issue_at   = cyc + 1;
      busy_until = cyc + LAT;
      done_at    = cyc + LAT + 1;
      if (cur_we) ref_mem[cur_addr[3:0]] = cur_wdata;
      else        cur_rval = ref_mem[cur_addr[3:0]];
    end
    g_cpu = ec;
    g_ext = ee;
    cyc++;
  endtask

  initial begin
    resetn = 1'b1; init_mem = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_halt = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    busy_until = -1; issue_at = -1; done_at = -1;
    own_cpu = 0; cur_we = 0; last_cpu = 0; exp_halted = 0; post_rst = 0;
    g_cpu = 0; g_ext = 0; rst_arm = 0;
    cur_addr = '0; cur_wdata = '0; cur_rval = '0; exp_cpu_rd = '0; exp_ext_rd = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0; init_mem = 1'b0;

    @(negedge clk);
    chk("rst_cpu_gnt", cpu_gnt, 0);    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_cpu_done", cpu_done, 0);  chk("rst_ext_done", ext_done, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_ext_rdata", ext_rdata, 0);
    chk("rst_halted", cpu_halted, 0);
    chk("rst_mem_read", mem_read, 0);  chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);  chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;

    for (int n = 0; n < NCYC; n++) begin
      // Reset lands in the first wait cycle of a transaction every few hundred cycles.
      if (n % 600 == 599) rst_arm = 1'b1;
      if (rst_arm && issue_at == cyc - 1) begin
        resetn = 1'b1; rst_arm = 1'b0;
      end else resetn = 1'b0;

      if (g_cpu ? ($urandom_range(0, 1) == 1) : (!cpu_req && $urandom_range(0, 3) == 0)) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 32'($urandom_range(0, 15)); cpu_wdata = $urandom;
      end else if (g_cpu || (cpu_req && $urandom_range(0, 15) == 0)) cpu_req = 1'b0;

      if (g_ext ? ($urandom_range(0, 1) == 1) : (!ext_req && $urandom_range(0, 3) == 0)) begin
        ext_req = 1'b1; ext_we = 1'($urandom_range(0, 1));
        ext_addr = 32'($urandom_range(0, 15)); ext_wdata = $urandom;
      end else if (g_ext || (ext_req && $urandom_range(0, 15) == 0)) ext_req = 1'b0;

      if ($urandom_range(0, 24) == 0) ext_halt = ~ext_halt;

      @(negedge clk);
      model_step();
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
